// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_pkg                                                   |
// | Purpose  : Shared types and defaults for the data-memory responder.  |
// |            Provides the responder state encoding, default depth and  |
// |            read latency, and the word-index width helper.            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_LAT   = 2;

  // Word-index width for a RAM of 'depth' words (at least one bit).
  function automatic int dmem_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DMEM_IDX_W = dmem_idx_w(DMEM_DEPTH);

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_ram                                                   |
// | Purpose  : Single-port word RAM, synchronous write, combinational    |
// |            read. Contents are not reset.                             |
// | Ports    : clk   - clock, rising edge                                 |
// |            we    - write enable                                       |
// |            addr  - word index (shared by read and write)              |
// |            wdata - write data                                         |
// |            rdata - read data at addr (combinational)                  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DMEM_DEPTH,
  localparam int AW   = dmem_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder                                             |
// | Purpose  : Memory side of the datapath load/store interface. Stores  |
// |            commit in the accepting cycle; loads return after LAT     |
// |            cycles with a one-cycle rvalid strobe. ready paces loads. |
// | Ports    : clk, reset (sync, active-high)                             |
// |            req, memWrite, addr, writeData - request side              |
// |            ready, rvalid, readData        - response side             |
// |            misaligned - only when DMEM_ALIGN_CHECK_EN is defined      |
// | Config   : DMEM_ALIGN_CHECK_EN - reject requests with addr[1:0] != 0 |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LAT   = DMEM_LAT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         memWrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writeData,
  output logic         ready,
  output logic         rvalid,
  output logic [n-1:0] readData
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic         misaligned
`endif
);

  localparam int IW = dmem_idx_w(DEPTH);
  // Counter only ever holds values up to LAT-2.
  localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT >= 2) ? (LAT - 2) : 0);

  dmem_state_t   state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] lat_idx;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] ram_addr;
  logic [n-1:0]  ram_rdata;
  logic          ram_we;
  logic          accept;
  logic          aligned;
  logic          perform;
  logic          unused_addr_bits;

  assign cur_idx = addr[IW+1:2];
  assign ready   = (state == IDLE);
  assign accept  = req && ready;

`ifdef DMEM_ALIGN_CHECK_EN
  assign aligned = (addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  assign perform = accept && aligned;
  // Reset wins over a coincident store.
  assign ram_we  = perform && memWrite && !reset;

  // Stores only happen in IDLE, so the single RAM port follows the live
  // address there and the latched load address otherwise.
  assign ram_addr = (state == IDLE) ? cur_idx : lat_idx;

  // High address bits wrap; low bits are byte offsets within the word.
  assign unused_addr_bits = ^{addr[n-1:IW+2], addr[1:0]};

  dmem_ram #(
    .WIDTH (n),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (writeData),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      rvalid   <= 1'b0;
      readData <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      rvalid <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      misaligned <= accept && !aligned;
`endif
      case (state)
        IDLE: begin
          if (perform && !memWrite) begin
            lat_idx <= cur_idx;
            if (LAT == 1) begin
              // Capture the response on the entry edge so it is on
              // readData during the RESP cycle itself.
              state    <= RESP;
              rvalid   <= 1'b1;
              readData <= ram_rdata;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= RESP;
            rvalid   <= 1'b1;
            readData <= ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
